// File: rtl/rs232_rx_pkg.sv
// rs232_rx_pkg -- shared constants for the RS232 receiver (and the matching
// transmitter): FSM state encodings, oversampling tick indices and the
// baud-divider helper.
// Ports: none (package).
package rs232_rx_pkg;

  // Ticks per bit; the tick indices below are only meaningful for 16.
  localparam int OVERSAMPLE = 16;

  // Tick indices within one bit period.
  localparam logic [3:0] T_S0   = 4'd6;
  localparam logic [3:0] T_S1   = 4'd7;
  localparam logic [3:0] T_S2   = 4'd8;
  localparam logic [3:0] T_LAST = 4'd15;

  // FSM state encodings.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  // Clocks per sample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/rs232_rx_if.sv
// rs232_rx_if -- serial line and byte-output bundle of the RS232 receiver.
// Signals: RXD (serial in, idles high), RS_DATAOUT[7:0] (last good byte),
//          RS_DONE (byte pulse), FRAME_ERR (bad stop pulse), BUSY (frame in
//          progress), PARITY_ERR (only when RS232_RX_PARITY_EN is defined).
// Modports: master = receiver side, slave = line driver / byte consumer.
interface rs232_rx_if;
  logic       RXD;
  logic [7:0] RS_DATAOUT;
  logic       RS_DONE;
  logic       FRAME_ERR;
  logic       BUSY;
`ifdef RS232_RX_PARITY_EN
  logic       PARITY_ERR;
`endif

  modport master (
    input  RXD,
    output RS_DATAOUT, RS_DONE, FRAME_ERR, BUSY
`ifdef RS232_RX_PARITY_EN
    , PARITY_ERR
`endif
  );

  modport slave (
    output RXD,
    input  RS_DATAOUT, RS_DONE, FRAME_ERR, BUSY
`ifdef RS232_RX_PARITY_EN
    , PARITY_ERR
`endif
  );
endinterface

// File: rtl/rs232_baud_tick.sv
// rs232_baud_tick -- free-running modulo-DIV counter producing a one-clock
// sample tick every DIV clocks.
// Ports: CLK_50MHZ (clock), RST_N (async active-low reset),
//        clr (restart the period, aligns the phase to a start edge),
//        tick (one-clock pulse, first one DIV clocks after clr).
module rs232_baud_tick #(
  parameter int DIV = 27
) (
  input  logic CLK_50MHZ,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (clr) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (cnt_reg == CW'(DIV - 1)) begin
      cnt_reg <= '0;
      tick    <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      tick    <= 1'b0;
    end
  end
endmodule

// File: rtl/rs232_rx.sv
// rs232_rx -- 8N1 RS232 receiver, 16x oversampling with 3-sample majority.
// Ports: CLK_50MHZ (clock), RST_N (async active-low reset),
//        bus (rs232_rx_if.master): RXD in; RS_DATAOUT, RS_DONE, FRAME_ERR,
//        BUSY out (PARITY_ERR too when the parity option is built in).
// Build option: RS232_RX_PARITY_EN adds one even-parity bit after the data
// bits and the PARITY_ERR pulse output.
module rs232_rx
  import rs232_rx_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = calc_div(CLK_HZ, BAUD)
) (
  input  logic CLK_50MHZ,
  input  logic RST_N,
  rs232_rx_if.master bus
);
  logic       meta_reg, rxs;
  logic [2:0] state_reg;
  logic [3:0] t_reg;
  logic [2:0] bit_reg;
  logic       s0_reg, s1_reg;
  logic [7:0] shreg_reg;
  logic [7:0] dataout_reg;
  logic       done_reg, ferr_reg;
  logic       tick, clr, vote;
`ifdef RS232_RX_PARITY_EN
  logic       par_reg, perr_reg;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      meta_reg <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      meta_reg <= bus.RXD;
      rxs      <= meta_reg;
    end
  end

  // Restart the tick phase on the start edge so t=8 lands near mid-bit.
  assign clr = (state_reg == IDLE) && !rxs;

  rs232_baud_tick #(.DIV(DIV)) u_tick (
    .CLK_50MHZ (CLK_50MHZ),
    .RST_N     (RST_N),
    .clr       (clr),
    .tick      (tick)
  );

  // Third sample is the live value at t=8.
  assign vote = (s0_reg & s1_reg) | (s0_reg & rxs) | (s1_reg & rxs);

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      t_reg       <= '0;
      bit_reg     <= '0;
      s0_reg      <= 1'b1;
      s1_reg      <= 1'b1;
      shreg_reg   <= '0;
      dataout_reg <= '0;
      done_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      par_reg     <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      ferr_reg <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      perr_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          t_reg   <= '0;
          bit_reg <= '0;
          if (!rxs) state_reg <= START;
        end
        BREAK: begin
          // One FRAME_ERR per break: stay here until the line is released.
          if (rxs) state_reg <= IDLE;
        end
        START, DATA, PARITY, STOP: begin
          if (tick) begin
            t_reg <= t_reg + 4'd1;   // wraps 15 -> 0 at the bit boundary
            if (t_reg == T_S0) s0_reg <= rxs;
            if (t_reg == T_S1) s1_reg <= rxs;
            if (t_reg == T_S2) begin
              case (state_reg)
                START: if (vote) state_reg <= IDLE;  // glitch, not a start bit
                DATA:  shreg_reg <= {vote, shreg_reg[7:1]};
`ifdef RS232_RX_PARITY_EN
                PARITY: par_reg <= vote;
`endif
                STOP: begin
                  // Decide at mid-stop so a following start edge is caught.
                  if (!vote) begin
                    ferr_reg  <= 1'b1;
                    state_reg <= BREAK;
                  end else begin
                    state_reg <= IDLE;
`ifdef RS232_RX_PARITY_EN
                    if (^{shreg_reg, par_reg}) begin
                      perr_reg <= 1'b1;
                    end else begin
                      dataout_reg <= shreg_reg;
                      done_reg    <= 1'b1;
                    end
`else
                    dataout_reg <= shreg_reg;
                    done_reg    <= 1'b1;
`endif
                  end
                end
                default: ;
              endcase
            end
            if (t_reg == T_LAST) begin
              case (state_reg)
                START: state_reg <= DATA;
                DATA: begin
                  if (bit_reg == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                    state_reg <= PARITY;
`else
                    state_reg <= STOP;
`endif
                  end else begin
                    bit_reg <= bit_reg + 3'd1;
                  end
                end
                PARITY: state_reg <= STOP;
                default: ;
              endcase
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.RS_DATAOUT = dataout_reg;
  assign bus.RS_DONE    = done_reg;
  assign bus.FRAME_ERR  = ferr_reg;
  assign bus.BUSY       = (state_reg != IDLE);
`ifdef RS232_RX_PARITY_EN
  assign bus.PARITY_ERR = perr_reg;
`endif
endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx -- self-checking bench for rs232_rx. A behavioural serializer
// drives RXD; each issued frame pushes its expected outcome (computed from
// the frame contents) into a queue, and a monitor pops and compares on every
// RS_DONE / FRAME_ERR / PARITY_ERR pulse.
module tb_rs232_rx;
  localparam int BIT = 432;
  localparam logic [1:0] EV_DONE = 2'd0;
  localparam logic [1:0] EV_FERR = 2'd1;
  localparam logic [1:0] EV_PERR = 2'd2;
`ifdef RS232_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic CLK_50MHZ = 1'b0;
  logic RST_N     = 1'b0;
  always #10 CLK_50MHZ = ~CLK_50MHZ;

  rs232_rx_if bus();

  rs232_rx dut (
    .CLK_50MHZ (CLK_50MHZ),
    .RST_N     (RST_N),
    .bus       (bus)
  );

  logic perr_s;
`ifdef RS232_RX_PARITY_EN
  assign perr_s = bus.PARITY_ERR;
`else
  assign perr_s = 1'b0;
`endif

  ev_t        exp_q[$];
  logic [7:0] model_dout = 8'h00;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: what a receiver must report for one complete frame.
  function automatic ev_t frame_model(input logic [7:0] d, input logic stop_bit,
                                      input logic par_bit);
    ev_t e;
    if (!stop_bit)                        e = '{kind: EV_FERR, data: model_dout};
    else if (PAR_EN && (par_bit != ^d))   e = '{kind: EV_PERR, data: model_dout};
    else                                  e = '{kind: EV_DONE, data: d};
    return e;
  endfunction

  task automatic drive_bit(input logic v, input int n);
    bus.RXD = v;
    repeat (n) @(negedge CLK_50MHZ);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_bit, input int bclk);
    ev_t e;
    e = frame_model(d, stop_bit, par_bit);
    exp_q.push_back(e);
    if (e.kind == EV_DONE) model_dout = d;
    $display("tx byte=0x%02h stop=%0d par=%0d bitclks=%0d", d, stop_bit, par_bit, bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
    if (PAR_EN) drive_bit(par_bit, bclk);
    drive_bit(stop_bit, bclk);
  endtask

  task automatic send_good(input logic [7:0] d, input int bclk);
    send_frame(d, 1'b1, ^d, bclk);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge CLK_50MHZ);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor / scoreboard.
  logic       prev_done = 1'b0;
  logic [7:0] prev_dout = 8'h00;
  always @(negedge CLK_50MHZ) begin
    if (RST_N) begin
      if (bus.RS_DONE) begin
        check("done_width", {31'd0, prev_done}, 32'd0);
        check("done_ferr_excl", {31'd0, bus.FRAME_ERR | perr_s}, 32'd0);
      end
      if (bus.RS_DATAOUT != prev_dout)
        check("dout_change_qualified", {31'd0, bus.RS_DONE}, 32'd1);
      if (bus.RS_DONE || bus.FRAME_ERR || perr_s) begin
        logic [1:0] kind;
        kind = bus.RS_DONE ? EV_DONE : (bus.FRAME_ERR ? EV_FERR : EV_PERR);
        $display("rx event kind=%0d dataout=0x%02h", kind, bus.RS_DATAOUT);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event_kind", {30'd0, kind}, {30'd0, e.kind});
          check("event_data", {24'd0, bus.RS_DATAOUT}, {24'd0, e.data});
        end
      end
    end
    prev_done <= bus.RS_DONE;
    prev_dout <= bus.RS_DATAOUT;
  end

  initial begin
    int cnt;
    int bclk;
    logic [7:0] d;
    logic bad_stop;
    logic bad_par;

    bus.RXD = 1'b1;
    repeat (5) @(negedge CLK_50MHZ);
    check("rst_dataout", {24'd0, bus.RS_DATAOUT}, 32'd0);
    check("rst_done", {31'd0, bus.RS_DONE}, 32'd0);
    check("rst_ferr", {31'd0, bus.FRAME_ERR}, 32'd0);
    check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    RST_N = 1'b1;
    repeat (50) @(negedge CLK_50MHZ);

    // 1: 0x55, BUSY length about 9.5 bits.
    cnt = 0;
    fork
      send_good(8'h55, BIT);
      repeat (11 * BIT) begin
        @(negedge CLK_50MHZ);
        if (bus.BUSY) cnt++;
      end
    join
    drain(BIT);
    check("busy_len_in_range", {31'd0, (cnt >= 9 * BIT) && (cnt <= 10 * BIT)}, 32'd1);

    // 2: 150-clock low glitch is rejected within one bit time.
    cnt = 0;
    bus.RXD = 1'b0;
    repeat (150) begin
      @(negedge CLK_50MHZ);
      if (bus.BUSY) cnt++;
    end
    bus.RXD = 1'b1;
    repeat (BIT - 150) @(negedge CLK_50MHZ);
    check("glitch_busy_seen", {31'd0, cnt > 0}, 32'd1);
    check("glitch_busy_cleared", {31'd0, bus.BUSY}, 32'd0);
    repeat (BIT) @(negedge CLK_50MHZ);

    // 3: good byte, framing error, long break, recovery.
    send_good(8'h3C, BIT);
    send_frame(8'hA3, 1'b0, ^8'hA3, BIT);
    drive_bit(1'b0, 30 * BIT);
    check("break_busy", {31'd0, bus.BUSY}, 32'd1);
    check("break_dout_hold", {24'd0, bus.RS_DATAOUT}, {24'd0, model_dout});
    drive_bit(1'b1, BIT);
    check("break_released", {31'd0, bus.BUSY}, 32'd0);
    send_good(8'h0F, BIT);
    drive_bit(1'b1, BIT);
    drain(BIT);

    // 4: back-to-back, no idle gap.
    send_good(8'h00, BIT);
    send_good(8'hFF, BIT);
    send_good(8'h81, BIT);
    drive_bit(1'b1, BIT);
    drain(BIT);

    // 5: +/-3% baud, then reset mid-byte.
    send_good(8'h7E, 419);
    drive_bit(1'b1, BIT);
    send_good(8'h7E, 445);
    drive_bit(1'b1, BIT);
    drain(BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, 200);
    #3;
    RST_N = 1'b0;
    #1;
    check("midrst_dataout", {24'd0, bus.RS_DATAOUT}, 32'd0);
    check("midrst_busy", {31'd0, bus.BUSY}, 32'd0);
    model_dout = 8'h00;
    bus.RXD = 1'b1;
    repeat (10) @(negedge CLK_50MHZ);
    RST_N = 1'b1;
    drive_bit(1'b1, BIT);
    send_good(8'h5A, BIT);
    drive_bit(1'b1, BIT);
    drain(BIT);

`ifdef RS232_RX_PARITY_EN
    // 6: parity error then correct parity.
    send_frame(8'h07, 1'b1, 1'b0, BIT);
    drive_bit(1'b1, BIT);
    send_frame(8'h07, 1'b1, 1'b1, BIT);
    drive_bit(1'b1, BIT);
    drain(BIT);
`endif

    // Randomized frames: data, baud offset within +/-2%, stop/parity errors.
    for (int k = 0; k < 4; k++) begin
      d        = 8'($urandom_range(0, 255));
      bclk     = BIT - 8 + int'($urandom_range(0, 16));
      bad_stop = ($urandom_range(0, 3) == 0);
      bad_par  = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(d, !bad_stop, (^d) ^ bad_par, bclk);
      if (bad_stop) drive_bit(1'b1, BIT);
      else          drive_bit(1'b1, int'($urandom_range(1, 100)));
    end
    drain(2 * BIT);
    check("final_dataout", {24'd0, bus.RS_DATAOUT}, {24'd0, model_dout});
    check("final_busy", {31'd0, bus.BUSY}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
